// File: rtl/method_arb_pkg.sv
// Shared types for the method-call arbiter.
// State encoding is 32-bit to line up with the generated object state regs.
package method_arb_pkg;

  typedef enum logic [31:0] {
    IDLE  = 32'd0,
    ISSUE = 32'd1,
    ACK   = 32'd2,
    RUN   = 32'd3,
    DONE  = 32'd4
  } state_t;

endpackage

// File: rtl/method_call_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after 'last'.
// Scans last+1, last+2, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/method_call_arbiter.sv
// Shares one generated-object method port between NUM_REQ requesters.
// Round-robin grant, one-cycle m_req, busy handshake, return capture.
module method_call_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ARG_W       = 32,
  parameter int RET_W       = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_call,
  input  logic [NUM_REQ*ARG_W-1:0] req_arg,
  output logic [NUM_REQ-1:0]       req_busy,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [RET_W-1:0]         req_ret,
  output logic                     req_err,
  output logic                     m_req,
  output logic [ARG_W-1:0]         m_arg,
  input  logic                     m_busy,
  input  logic [RET_W-1:0]         m_ret,
  output logic                     err_sticky
);
  import method_arb_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW =
    (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t               state;
  state_t               state_n;
  logic [IW-1:0]        last;
  logic [NUM_REQ-1:0]   busy_q;
  logic [ARG_W-1:0]     arg_q;
  logic [RET_W-1:0]     ret_q;
  logic                 sticky;
  logic [CW-1:0]        cnt;
  logic                 to_q;
  logic                 to_n;
  logic                 cnt_hit;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req  (req_call),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Counter starts at 0 one cycle after m_req, so +2 gives
  // cycles elapsed since m_req at the point DONE is reached.
  assign cnt_hit =
    (32'(cnt) + 32'd2) >= 32'(ACK_TIMEOUT);

  always_comb begin
    state_n = state;
    to_n    = to_q;
    unique case (state)
      IDLE: begin
        to_n = 1'b0;
        if (pick_any && !m_busy) state_n = ISSUE;
      end
      ISSUE: begin
        if (m_busy) begin
          state_n = RUN;
        end else if (ACK_TIMEOUT == 1) begin
          state_n = DONE;
          to_n    = 1'b1;
        end else begin
          state_n = ACK;
        end
      end
      ACK: begin
        if (m_busy) begin
          state_n = RUN;
        end else if (ACK_TIMEOUT != 0 && cnt_hit) begin
          state_n = DONE;
          to_n    = 1'b1;
        end
      end
      RUN: begin
        if (!m_busy) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= IW'(NUM_REQ - 1);
      busy_q <= '0;
      arg_q  <= '0;
      ret_q  <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
      to_q   <= 1'b0;
    end else begin
      state <= state_n;
      to_q  <= to_n;
      unique case (state)
        IDLE: begin
          if (state_n == ISSUE) begin
            arg_q  <= req_arg[pick_idx*ARG_W +: ARG_W];
            busy_q <= pick_gnt;
            last   <= pick_idx;
          end
        end
        ISSUE: cnt <= '0;
        ACK: begin
          if (32'(cnt) < 32'(ACK_TIMEOUT))
            cnt <= cnt + 1'b1;
        end
        RUN: begin
          if (!m_busy) ret_q <= m_ret;
        end
        DONE: begin
          busy_q <= '0;
          if (to_q) sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_busy   = busy_q;
  assign req_done   = (state == DONE) ? busy_q : '0;
  assign req_err    = (state == DONE) && to_q;
  assign m_req      = (state == ISSUE);
  assign m_arg      = arg_q;
  assign req_ret    = ret_q;
  assign err_sticky = sticky;

endmodule

// File: tb/tb_method_call_arbiter.sv
// Scoreboard bench for method_call_arbiter.
// Behavioural callee returns arg*5 after a configurable busy time.
module tb_method_call_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int RW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [7:0]    who;
    logic [RW-1:0] ret;
    logic          err;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_call;
  logic [N*AW-1:0] req_arg;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    req_done;
  logic [RW-1:0]   req_ret;
  logic            req_err;
  logic            m_req;
  logic [AW-1:0]   m_arg;
  logic            m_busy;
  logic [RW-1:0]   m_ret;
  logic            err_sticky;

  method_call_arbiter #(
    .NUM_REQ     (N),
    .ARG_W       (AW),
    .RET_W       (RW),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_call   (req_call),
    .req_arg    (req_arg),
    .req_busy   (req_busy),
    .req_done   (req_done),
    .req_ret    (req_ret),
    .req_err    (req_err),
    .m_req      (m_req),
    .m_arg      (m_arg),
    .m_busy     (m_busy),
    .m_ret      (m_ret),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int            lat      = 2;
  bit            never    = 1'b0;
  bit            fast     = 1'b0;
  int            busy_cnt = 0;
  logic [RW-1:0] ret_reg  = '0;

  always @(posedge clk) begin
    if (m_req && !never) begin
      busy_cnt <= lat;
      ret_reg  <= RW'(m_arg * 32'd5);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign m_busy = (busy_cnt > 0) || (fast && m_req);
  assign m_ret  = ret_reg;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mreq_cnt = 0;
  int            grant_cnt = 0;
  int            mreq_cyc = 0;
  int            grant_cyc = 0;
  int            onehot_bad = 0;
  logic [N-1:0]  drop_mask = '1;
  logic [N-1:0]  prev_busy = '0;
  logic [RW-1:0] ret_model = '0;
  ev_t           exp_q[$];
  ev_t           obs_q[$];
  int            obs_cyc[$];

  task automatic cycle();
    ev_t o;
    @(negedge clk);
    cyc++;
    if (m_req) begin
      mreq_cnt++;
      mreq_cyc = cyc;
    end
    if ($countones(req_busy) > 1) onehot_bad++;
    if (req_busy != '0 && prev_busy == '0) begin
      grant_cnt++;
      grant_cyc = cyc;
    end
    prev_busy = req_busy;
    if (req_done != '0) begin
      o.who = 8'hFF;
      for (int i = 0; i < N; i++)
        if (req_done == (N'(1) << i)) o.who = 8'(i);
      o.ret = req_ret;
      o.err = req_err;
      obs_q.push_back(o);
      obs_cyc.push_back(cyc);
      req_call = req_call & ~(req_done & drop_mask);
    end
  endtask

  task automatic push_call(input int who, input bit err);
    ev_t e;
    e.who = 8'(who);
    e.err = err;
    if (!err)
      ret_model = RW'(req_arg[who*AW +: AW] * 32'd5);
    e.ret = ret_model;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req_call = '0;
    req_arg  = '0;
    repeat (3) cycle();
    checks++;
    if (req_busy !== '0 || req_done !== '0) begin
      errors++;
      $display("FAIL reset_busy_done got %b/%b want 0/0",
               req_busy, req_done);
    end
    checks++;
    if ({m_req, req_err, err_sticky} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {m_req, req_err, err_sticky});
    end
    checks++;
    if (m_arg !== '0 || req_ret !== '0) begin
      errors++;
      $display("FAIL reset_data got %0h/%0h want 0/0",
               m_arg, req_ret);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    int m0;
    ev_t e, o;
    m0 = mreq_cnt;
    lat = 4;
    req_arg[0*AW +: AW] = 32'd5;
    req_call = 4'b0001;
    push_call(0, 1'b0);
    for (int c = 0; c < 100 && obs_q.size() < 1; c++)
      cycle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL single_done_count got %0d want 1",
               obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
    end
    checks++;
    if (m_arg !== 32'd5) begin
      errors++;
      $display("FAIL single_m_arg got %0d want 5", m_arg);
    end
    repeat (6) cycle();
    checks++;
    if (mreq_cnt - m0 != 1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL single_extra got mreq %0d done %0d want 1/0",
               mreq_cnt - m0, obs_q.size());
    end
  endtask

  task automatic test_contention();
    ev_t e, o;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    onehot_bad = 0;
    lat = 2;
    drop_mask = '0;
    for (int i = 0; i < N; i++)
      req_arg[i*AW +: AW] = 32'(10 + i);
    req_call = 4'b1111;
    for (int i = 0; i < 5; i++) push_call(i % N, 1'b0);
    for (int c = 0; c < 300 && obs_q.size() < 5; c++)
      cycle();
    req_call = '0;
    drop_mask = '1;
    checks++;
    if (obs_q.size() != 5) begin
      errors++;
      $display("FAIL rr_done_count got %0d want 5", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rr_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
    end
    exp_q.delete();
    repeat (8) cycle();
    checks++;
    if (onehot_bad != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL rr_onehot got %0d bad, %0d extra want 0/0",
               onehot_bad, obs_q.size());
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    int dc;
    never = 1'b1;
    req_arg[1*AW +: AW] = 32'd7;
    req_call = 4'b0010;
    push_call(1, 1'b1);
    for (int c = 0; c < 100 && obs_q.size() < 1; c++)
      cycle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL to_done_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      dc = obs_cyc.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL to_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
      checks++;
      if (dc - mreq_cyc != TO) begin
        errors++;
        $display("FAIL to_latency got %0d want %0d",
                 dc - mreq_cyc, TO);
      end
    end
    cycle();
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky got %b want 1", err_sticky);
    end
    never = 1'b0;
    lat = 1;
    req_arg[2*AW +: AW] = 32'd3;
    req_call = 4'b0100;
    push_call(2, 1'b0);
    for (int c = 0; c < 100 && obs_q.size() < 1; c++)
      cycle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL to_next_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      checks++;
      if (o !== e || err_sticky !== 1'b1) begin
        errors++;
        $display("FAIL to_next_ev got %0h/%0d/%b/%b want %0h/%0d/%b/1",
                 o.who, o.ret, o.err, err_sticky,
                 e.who, e.ret, e.err);
      end
    end
    cycle();
  endtask

  task automatic test_fast();
    ev_t e, o;
    int dc, m0;
    m0 = mreq_cnt;
    fast = 1'b1;
    lat = 0;
    req_arg[3*AW +: AW] = 32'd9;
    req_call = 4'b1000;
    push_call(3, 1'b0);
    for (int c = 0; c < 50 && obs_q.size() < 1; c++)
      cycle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL fast_done_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      dc = obs_cyc.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fast_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
      checks++;
      if (dc - (grant_cyc - 1) != 3) begin
        errors++;
        $display("FAIL fast_latency got %0d want 3",
                 dc - (grant_cyc - 1));
      end
    end
    repeat (4) cycle();
    checks++;
    if (mreq_cnt - m0 != 1) begin
      errors++;
      $display("FAIL fast_mreq got %0d want 1", mreq_cnt - m0);
    end
    fast = 1'b0;
  endtask

  task automatic test_midop_reset();
    ev_t e, o;
    int m0, bad;
    m0 = mreq_cnt;
    bad = 0;
    lat = 8;
    req_arg[1*AW +: AW] = 32'd4;
    req_call = 4'b0010;
    for (int c = 0; c < 50 && mreq_cnt == m0; c++)
      cycle();
    repeat (3) cycle();
    reset = 1'b1;
    lat = 3;
    for (int i = 0; i < N; i++)
      req_arg[i*AW +: AW] = 32'(20 + i);
    req_call = 4'b1111;
    exp_q.delete();
    cycle();
    checks++;
    if (req_busy !== '0 || m_req !== 1'b0 ||
        m_arg !== '0 || req_ret !== '0 ||
        err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b/%b/%0h/%0h/%b want 0",
               req_busy, m_req, m_arg, req_ret, err_sticky);
    end
    reset = 1'b0;
    ret_model = '0;
    for (int i = 0; i < N; i++) push_call(i, 1'b0);
    for (int c = 0; c < 50 && m_busy; c++) begin
      cycle();
      if (m_busy && (req_busy != '0 || m_req)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_wait got %0d early grants want 0", bad);
    end
    for (int c = 0; c < 200 && obs_q.size() < N; c++)
      cycle();
    checks++;
    if (obs_q.size() != N) begin
      errors++;
      $display("FAIL midrst_done_count got %0d want %0d",
               obs_q.size(), N);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midrst_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_drop();
    ev_t e, o;
    int m0, g0;
    m0 = mreq_cnt;
    lat = 5;
    req_arg[2*AW +: AW] = 32'd11;
    req_call = 4'b0100;
    push_call(2, 1'b0);
    for (int c = 0; c < 50 && mreq_cnt == m0; c++)
      cycle();
    g0 = grant_cnt;
    repeat (2) cycle();
    req_call[2] = 1'b0;
    for (int c = 0; c < 50 && obs_q.size() < 1; c++)
      cycle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL drop_done_count got %0d want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drop_ev got %0h/%0d/%b want %0h/%0d/%b",
                 o.who, o.ret, o.err, e.who, e.ret, e.err);
      end
    end
    repeat (10) cycle();
    checks++;
    if (grant_cnt != g0 || req_busy !== '0) begin
      errors++;
      $display("FAIL drop_regrant got %0d grants busy %b want 0/0",
               grant_cnt - g0, req_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_fast();
    test_midop_reset();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
